// File: rtl/modn_cascade_counter_if.sv
// Bus bundle for the mod-N cascade counter: control inputs, count and terminal-count outputs.
// There is no handshake; every input is level-sampled on each rising clk edge.
interface modn_cascade_counter_if #(
  parameter int N      = 10,
  parameter int DIGITS = 2
);
  localparam int W = (N <= 2) ? 1 : $clog2(N);

  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [DIGITS*W-1:0]   load_val;
  logic                  clr_ovf;
  logic [DIGITS*W-1:0]   count;
  logic [DIGITS-1:0]     digit_tc;
  logic                  tc;
  logic                  ovf;

  modport master (
    output en, up_dn, load, load_val, clr_ovf,
    input  count, digit_tc, tc, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val, clr_ovf,
    output count, digit_tc, tc, ovf
  );
endinterface

// File: rtl/modn_cascade_counter.sv
// Cascaded mod-N up/down counter with single-cycle carry/borrow resolution,
// clamped parallel load, sticky overflow and optional saturation at the full-count boundary.
module modn_cascade_counter #(
  parameter int N        = 10,
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  modn_cascade_counter_if.slave bus
);
  localparam int W = (N <= 2) ? 1 : $clog2(N);
  localparam logic [W-1:0] MAX_V = W'(N - 1);
  localparam logic [W:0]   MAX_X = (W + 1)'(N - 1);
  localparam logic [W:0]   N_X   = (W + 1)'(N);

  logic [DIGITS*W-1:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   digit_tc;
  logic [DIGITS-1:0]   step_en;
  logic                tc;

  // Out-of-range digits never count as terminal; they recover on their next step.
  function automatic logic [W-1:0] step_digit(input logic [W-1:0] d, input logic up);
    logic [W-1:0] r;
    if (up) begin
      r = ({1'b0, d} >= MAX_X) ? '0 : d + 1'b1;
    end else begin
      r = (d == '0 || {1'b0, d} >= N_X) ? MAX_V : d - 1'b1;
    end
    return r;
  endfunction

  // Carry chain: digit k steps when every lower digit is terminal, all in one cycle.
  always_comb begin
    logic run;
    logic at_term;
    run      = bus.en;
    step_en  = '0;
    digit_tc = '0;
    for (int k = 0; k < DIGITS; k++) begin
      at_term     = bus.up_dn ? (count_q[k*W +: W] == MAX_V) : (count_q[k*W +: W] == '0);
      step_en[k]  = run;
      run         = run & at_term;
      digit_tc[k] = run;
    end
  end

  assign tc = digit_tc[DIGITS-1];

  always_comb begin
    logic [W-1:0] lv;
    count_d = count_q;
    ovf_d   = ovf_q;
    lv      = '0;
    if (bus.load) begin
      for (int k = 0; k < DIGITS; k++) begin
        lv = bus.load_val[k*W +: W];
        count_d[k*W +: W] = ({1'b0, lv} >= N_X) ? MAX_V : lv;
      end
    end else if (bus.en && !(SATURATE && tc)) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (step_en[k]) count_d[k*W +: W] = step_digit(count_q[k*W +: W], bus.up_dn);
      end
    end
    // A boundary event overrides a same-cycle clear so no overflow is lost.
    if (bus.clr_ovf)           ovf_d = 1'b0;
    if (tc && !bus.load)       ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.digit_tc = digit_tc;
  assign bus.tc       = tc;
  assign bus.ovf      = ovf_q;
endmodule
